axi_ddr_bridge: RTL
===================

Name: axi_ddr_bridge

Overview:
Parametrised AXI4 slave that converts AXI write and read bursts into single-beat requests on the DDR controller's request/response port. It replaces direct testbench poking of the controller's logical_addr/pwdata/pwrite pins and sits between the AXI interface and ddrcntrl. It adds three things: INCR/FIXED burst address generation, round-robin arbitration between writes and reads, and a credit-controlled read-data FIFO so rready back-pressure never drops DDR data.

Parameters:
ADDR_W, 32, AXI and DDR address width
DATA_W, 32, data width in bits (power of 2, >=16)
ID_W, 4, AXI ID width
RD_FIFO_DEPTH, 4, read-data FIFO entries (power of 2, >=2)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-high reset
awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address
awvalid  in  1  write address valid; awready  out  1
wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data; wready  out  1
bid/bresp  out  ID_W/2  write response; bvalid  out  1; bready  in  1
arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address
arvalid  in  1  read address valid; arready  out  1
rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data; rvalid  out  1; rready  in  1
ddr_req_valid  out  1  backend request valid
ddr_req_ready  in  1  backend accepts request
ddr_req_write  out  1  1=write 0=read
ddr_req_addr  out  ADDR_W  beat address
ddr_req_wdata/ddr_req_wstrb  out  DATA_W/DATA_W/8  write beat
ddr_rsp_valid  in  1  read data returned, in order, always accepted
ddr_rsp_rdata  in  DATA_W  read data

Behaviour:
- One clock, aclk. Reset aresetn is synchronous and active-high. While aresetn=1: both FSMs go idle, FIFO is emptied, credit/outstanding counters are 0, arbiter priority goes to write, and every output is 0 except awready=arready=1. Reset mid-burst abandons the burst and no response is issued.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid it captures id/addr/len/size/burst, clears beat counter and error flag, and goes to W_DATA.
  - W_DATA: each wvalid beat becomes one ddr write with addr=current address, wdata/wstrb passed through.
  - wready = (state==W_DATA) && write_grant && ddr_req_ready (combinational pass-through, zero added latency).
  - The burst ends when beat counter reaches len. If wlast disagrees with the counter on any beat, the error flag is set and the count still governs.
- W_RESP: bvalid=1, bid=captured id, bresp=2'b10 if error flag else 2'b00. Held until bready, then W_IDLE. Writes are posted, so bvalid may assert the cycle after the last beat handshake.
- Read FSM R_IDLE -> R_ISSUE -> R_DRAIN -> R_IDLE.
  - R_IDLE: arready=1; captures the request on arvalid.
  - R_ISSUE: issues len+1 ddr reads. Each issue requires read_grant, ddr_req_ready and credit>0, where credit = RD_FIFO_DEPTH - fifo_count - outstanding. Issue increments outstanding; ddr_rsp_valid decrements it and pushes into the FIFO.
  - After the last issue: R_DRAIN until the last beat pops, then R_IDLE.
- rvalid = FIFO non-empty; rdata = FIFO head; rid = captured id. rlast=1 on pop index len. Pop happens on rvalid&&rready. Push and pop in the same cycle are both legal.
- Address generation: INCR adds 1<<size each beat, modulo 2^ADDR_W (no 4KB check). FIXED keeps the start address.
- Unsupported requests are burst==2'b10 (WRAP), burst==2'b11, or size > log2(DATA_W/8).
  - Write: wready=1 per beat with no ddr request; bresp=2'b10.
  - Read: len+1 FIFO entries of 0 are generated internally (credit rules still apply) with rresp=2'b10 and no ddr request.
- Arbiter: if only one side requests, it wins. If both request in the same cycle, the side not granted last time wins. Priority updates only on an accepted ddr request.
- ddr_req_valid is 1 whenever the granted side has a beat ready (write: wvalid in W_DATA; read: R_ISSUE with credit>0).

Test Plan:
- awaddr=0x100, awlen=3, awsize=2, INCR, wdata 0xA0..0xA3, ddr_req_ready=1 -> ddr writes to 0x100/0x104/0x108/0x10C in order; bresp=00 with bid=awid, one cycle after the last beat.
- araddr=0x200, arlen=7, FIXED, rready=0, backend latency 3 -> at most 4 ddr reads, all to 0x200; FIFO full. Then rready=1 -> remaining 4 issued; 8 beats returned, rlast only on beat 8, rresp=00.
- Write burst (len=3) and read burst (len=3) started in the same cycle, ddr_req_ready=1 -> ddr requests alternate W,R,W,R,W,R,W,R.
- awburst=WRAP, len=1 -> two wready handshakes, no ddr_req_valid, bresp=10. arsize=3 with DATA_W=32 -> two rdata=0 beats with rresp=10.
- awlen=2 with wlast asserted on beat 2 -> still 3 ddr writes, bresp=10.
- aresetn=1 pulsed mid read burst (outstanding=2) -> next cycle rvalid=0, arready=1, FIFO empty. A new read after reset completes with correct data.

Source files
------------

// File: rtl/axi_ddr_bridge.sv
// axi_ddr_bridge: AXI4 slave that turns write and read bursts into
// single-beat requests on the DDR controller's request/response port.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-high reset
//   aw* / w* / b*          AXI write address, data and response channels
//   ar* / r*               AXI read address and data channels
//   ddr_req_*              one beat per accepted request (valid/ready)
//   ddr_rsp_valid/rdata    in-order read data, always accepted
//
// Writes and reads compete for the single request port through a
// round-robin arbiter. Reads only issue while the read-data FIFO has a
// slot reserved for the returning beat, so rready back-pressure never
// loses backend data.
module axi_ddr_bridge #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int ID_W          = 4,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    output logic                ddr_req_valid,
    input  logic                ddr_req_ready,
    output logic                ddr_req_write,
    output logic [ADDR_W-1:0]   ddr_req_addr,
    output logic [DATA_W-1:0]   ddr_req_wdata,
    output logic [DATA_W/8-1:0] ddr_req_wstrb,
    input  logic                ddr_rsp_valid,
    input  logic [DATA_W-1:0]   ddr_rsp_rdata
);

    localparam int SIZE_MAX = $clog2(DATA_W / 8);
    localparam int PTR_W    = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;

    // WRAP, reserved burst type, or beats wider than the data bus.
    function automatic logic is_unsup(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'(SIZE_MAX));
    endfunction

    // INCR advances by the beat size and wraps at 2^ADDR_W; FIXED holds.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [1:0] burst,
                                                    input logic [2:0] size);
        return (burst == 2'b01) ? addr + (ADDR_W'(1) << size) : addr;
    endfunction

    w_state_t            w_state;
    logic [ID_W-1:0]     w_id;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_len, w_cnt;
    logic [2:0]          w_size;
    logic [1:0]          w_burst;
    logic                w_err, w_unsup;

    r_state_t            r_state;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len, r_icnt, r_pcnt;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic                r_unsup;

    logic [DATA_W-1:0]   fifo_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_count, outstanding;
    logic                prio_w;

    logic w_req, r_req, write_grant, read_grant, req_fire;
    logic credit_ok, r_fake, r_issue, r_pop, rsp_take, fifo_push, w_beat, beat_err;
    logic [CNT_W:0] used;

    // Every FIFO slot is either holding data or reserved for a read in flight.
    assign used      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit_ok = used < (CNT_W+1)'(RD_FIFO_DEPTH);

    assign w_req = !aresetn && (w_state == W_DATA) && !w_unsup && wvalid;
    assign r_req = !aresetn && (r_state == R_ISSUE) && !r_unsup && credit_ok;

    // Round-robin: on contention the side that did not win last time goes.
    assign write_grant = w_req && (!r_req || prio_w);
    assign read_grant  = r_req && (!w_req || !prio_w);
    assign req_fire    = ddr_req_valid && ddr_req_ready;

    // NOTE: every output of an always_comb gets a default first, so no path leaves a latch.
    always_comb begin
        ddr_req_valid = 1'b0;
        ddr_req_write = 1'b0;
        ddr_req_addr  = '0;
        ddr_req_wdata = '0;
        ddr_req_wstrb = '0;
        if (write_grant) begin
            ddr_req_valid = 1'b1;
            ddr_req_write = 1'b1;
            ddr_req_addr  = w_addr;
            ddr_req_wdata = wdata;
            ddr_req_wstrb = wstrb;
        end else if (read_grant) begin
            ddr_req_valid = 1'b1;
            ddr_req_addr  = r_addr;
        end
    end

    // Unsupported writes are swallowed beat by beat without touching DDR.
    assign wready   = !aresetn && (w_state == W_DATA) &&
                      (w_unsup || (write_grant && ddr_req_ready));
    assign w_beat   = wready && wvalid;
    assign beat_err = wlast != (w_cnt == w_len);

    // Unsupported reads still consume credit but fill the FIFO with zeros.
    assign r_fake    = !aresetn && (r_state == R_ISSUE) && r_unsup && credit_ok;
    assign r_issue   = r_fake || (read_grant && ddr_req_ready);
    // A response with nothing outstanding belongs to a burst abandoned by reset.
    assign rsp_take  = !aresetn && ddr_rsp_valid && (outstanding != '0);
    assign fifo_push = rsp_take || r_fake;

    assign rvalid = !aresetn && (fifo_count != '0);
    assign r_pop  = rvalid && rready;
    assign rdata  = rvalid ? fifo_mem[rd_ptr] : '0;
    assign rid    = rvalid ? r_id : '0;
    assign rresp  = (rvalid && r_unsup) ? 2'b10 : 2'b00;
    assign rlast  = rvalid && (r_pcnt == r_len);

    // Write FSM
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= 2'b00;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_unsup <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid) begin
                    w_id    <= awid;
                    w_addr  <= awaddr;
                    w_len   <= awlen;
                    w_size  <= awsize;
                    w_burst <= awburst;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_unsup <= is_unsup(awburst, awsize);
                    awready <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_beat) begin
                    w_addr <= next_addr(w_addr, w_burst, w_size);
                    w_cnt  <= w_cnt + 8'd1;
                    w_err  <= w_err || beat_err;
                    // The beat count, not wlast, decides where the burst ends.
                    if (w_cnt == w_len) begin
                        w_state <= W_RESP;
                        bvalid  <= 1'b1;
                        bid     <= w_id;
                        bresp   <= (w_err || beat_err || w_unsup) ? 2'b10 : 2'b00;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    bid     <= '0;
                    bresp   <= 2'b00;
                    awready <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM; r_pcnt tracks pops so rlast can be flagged on the final beat.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_icnt  <= '0;
            r_pcnt  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_unsup <= 1'b0;
        end else begin
            if (r_pop) r_pcnt <= r_pcnt + 8'd1;
            case (r_state)
                R_IDLE: if (arvalid) begin
                    r_id    <= arid;
                    r_addr  <= araddr;
                    r_len   <= arlen;
                    r_size  <= arsize;
                    r_burst <= arburst;
                    r_unsup <= is_unsup(arburst, arsize);
                    r_icnt  <= '0;
                    r_pcnt  <= '0;
                    arready <= 1'b0;
                    r_state <= R_ISSUE;
                end
                R_ISSUE: if (r_issue) begin
                    r_addr <= next_addr(r_addr, r_burst, r_size);
                    r_icnt <= r_icnt + 8'd1;
                    if (r_icnt == r_len) r_state <= R_DRAIN;
                end
                R_DRAIN: if (r_pop && rlast) begin
                    arready <= 1'b1;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // FIFO pointers, credit accounting and arbiter priority.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            prio_w      <= 1'b1;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (r_pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, r_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({read_grant && ddr_req_ready, rsp_take})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (req_fire) prio_w <= read_grant;
        end
    end

    // NOTE: the storage array is not reset; count and pointers alone define its valid contents.
    always_ff @(posedge aclk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= rsp_take ? ddr_rsp_rdata : '0;
    end

endmodule
